// File: rtl/jtdsp16_inst_fetch.sv
// DSP16 instruction fetch/decode front-end: IR latch, control-flow strobes, bubble sequencing.
// Optional interrupt entry/return logic is enabled by defining JTDSP16_ICALL_EN.
module jtdsp16_inst_fetch #(
    parameter int FLUSH_LEN = 1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic [15:0] rom_dout,
    input  logic        con_result,
    input  logic        irq,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        goto_ja,
    output logic        call_ja,
    output logic        goto_b,
    output logic        icall,
    output logic [11:0] ifield,
    output logic        con_check,
    output logic [4:0]  con_field,
    output logic        imm_we,
    output logic [15:0] imm_data,
    output logic        in_isr,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        FLUSH   = 3'd1,
        IMM     = 3'd2,
        SKIP    = 3'd3,
        SKIPIMM = 3'd4
    } state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_LEN - 1);
    localparam logic [4:0] OP_LIMM    = 5'b01010;

    state_t     state, state_nx;
    logic [1:0] cnt, cnt_nx;
    logic [4:0] op;
    logic       is_limm, transfer, take_irq;

    // ---------------- state register and datapath ----------------
    // The next state classifies the word loaded on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FLUSH;
            cnt      <= FLUSH_INIT;
            ir       <= 16'd0;
            ir_valid <= 1'b0;
            imm_we   <= 1'b0;
            imm_data <= 16'd0;
        end else if (cen) begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            ir       <= rom_dout;
            ir_valid <= (state_nx == RUN);
            imm_we   <= (state_nx == IMM);
            if (state_nx == IMM) imm_data <= rom_dout;
        end
    end

`ifdef JTDSP16_ICALL_EN
    logic iret;

    assign iret = goto_b && (ir[10:8] == 3'b001);
    // Only plain instructions may be interrupted so if/next and imm/data pairs stay atomic.
    assign take_irq = (state == RUN) && ir_valid && irq && !in_isr &&
                      !transfer && !is_limm && !con_check;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icall  <= 1'b0;
            in_isr <= 1'b0;
        end else if (cen) begin
            icall <= take_irq;
            if (take_irq)  in_isr <= 1'b1;
            else if (iret) in_isr <= 1'b0;
        end
    end
`else
    logic unused_irq;

    assign unused_irq = irq;
    assign take_irq   = 1'b0;
    assign icall      = 1'b0;
    assign in_isr     = 1'b0;
`endif

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: begin
                if (transfer || take_irq) begin
                    state_nx = FLUSH;
                    cnt_nx   = FLUSH_INIT;
                end else if (is_limm) begin
                    state_nx = IMM;
                end else if (con_check && !con_result) begin
                    state_nx = SKIP;
                end
            end
            FLUSH: begin
                if (cnt == 2'd0) state_nx = RUN;
                else             cnt_nx   = cnt - 2'd1;
            end
            IMM:     state_nx = RUN;
            SKIP:    state_nx = (op == OP_LIMM) ? SKIPIMM : RUN;
            SKIPIMM: state_nx = RUN;
            default: begin
                state_nx = FLUSH;
                cnt_nx   = FLUSH_INIT;
            end
        endcase
    end

    // ---------------- decode outputs ----------------
    always_comb begin
        op        = ir[15:11];
        goto_ja   = ir_valid && (op[4:1] == 4'b0000);
        call_ja   = ir_valid && (op[4:1] == 4'b1000);
        goto_b    = ir_valid && (op == 5'b11000);
        con_check = ir_valid && (op == 5'b11010);
        is_limm   = ir_valid && (op == OP_LIMM);
        transfer  = goto_ja || call_ja || goto_b || icall;
        ifield    = ir[11:0];
        con_field = ir[4:0];
        state_dbg = state;
    end

endmodule

// File: tb/tb_jtdsp16_inst_fetch.sv
// Directed bench for jtdsp16_inst_fetch (FLUSH_LEN=1); interrupt checks follow JTDSP16_ICALL_EN.
module tb_jtdsp16_inst_fetch;

    logic        rst, clk, cen, con_result, irq;
    logic [15:0] rom_dout;
    logic [15:0] ir, imm_data;
    logic        ir_valid, goto_ja, call_ja, goto_b, icall, con_check, imm_we, in_isr;
    logic [11:0] ifield;
    logic [4:0]  con_field;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    jtdsp16_inst_fetch #(.FLUSH_LEN(1)) dut (
        .rst        (rst),
        .clk        (clk),
        .cen        (cen),
        .rom_dout   (rom_dout),
        .con_result (con_result),
        .irq        (irq),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .goto_ja    (goto_ja),
        .call_ja    (call_ja),
        .goto_b     (goto_b),
        .icall      (icall),
        .ifield     (ifield),
        .con_check  (con_check),
        .con_field  (con_field),
        .imm_we     (imm_we),
        .imm_data   (imm_data),
        .in_isr     (in_isr),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking and driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present a ROM word, take one clock edge, sample 1ns later.
    task automatic cycle(input logic [15:0] w);
        rom_dout = w;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; cen = 1'b1; con_result = 1'b0; irq = 1'b0; rom_dout = 16'h0000;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ir",       ir,        16'h0000);
        check("rst_ir_valid", ir_valid,  1'b0);
        check("rst_imm_data", imm_data,  16'h0000);
        check("rst_imm_we",   imm_we,    1'b0);
        check("rst_goto_ja",  goto_ja,   1'b0);
        check("rst_in_isr",   in_isr,    1'b0);
        check("rst_icall",    icall,     1'b0);
        check("rst_state",    state_dbg, 3'd1);
        rst = 1'b0;

        // goto JA followed by one flushed word
        cycle(16'h0123);
        check("goto_valid",   ir_valid, 1'b1);
        check("goto_ja",      goto_ja,  1'b1);
        check("goto_ifield",  ifield,   12'h123);
        check("goto_call_ja", call_ja,  1'b0);
        cycle(16'h7777);
        check("flush_valid",  ir_valid, 1'b0);
        check("flush_goto",   goto_ja,  1'b0);
        cycle(16'h2000);
        check("after_flush_valid", ir_valid, 1'b1);
        check("after_flush_ir",    ir,       16'h2000);

        // cen low holds everything
        cen = 1'b0;
        cycle(16'h0456);
        check("cen_hold_ir",    ir,       16'h2000);
        check("cen_hold_valid", ir_valid, 1'b1);
        cen = 1'b1;

        // long immediate
        cycle(16'h5000);
        check("limm_valid",   ir_valid, 1'b1);
        check("limm_goto",    goto_ja,  1'b0);
        check("limm_imm_we",  imm_we,   1'b0);
        cycle(16'hBEEF);
        check("data_imm_we",   imm_we,   1'b1);
        check("data_imm_data", imm_data, 16'hBEEF);
        check("data_valid",    ir_valid, 1'b0);
        check("data_call_ja",  call_ja,  1'b0);
        check("data_goto_b",   goto_b,   1'b0);
        cycle(16'h2001);
        check("post_imm_we",   imm_we,   1'b0);
        check("post_imm_data", imm_data, 16'hBEEF);
        check("post_imm_valid", ir_valid, 1'b1);

        // if CON false skips the goto that follows
        cycle(16'hD005);
        check("con_check", con_check, 1'b1);
        check("con_field", con_field, 5'd5);
        con_result = 1'b0;
        cycle(16'h0200);
        check("skip_valid", ir_valid, 1'b0);
        check("skip_goto",  goto_ja,  1'b0);
        cycle(16'h2002);
        check("after_skip_valid", ir_valid, 1'b1);
        check("after_skip_ir",    ir,       16'h2002);

        // if CON true lets the goto execute
        cycle(16'hD005);
        con_result = 1'b1;
        cycle(16'h0300);
        check("con_true_valid", ir_valid, 1'b1);
        check("con_true_goto",  goto_ja,  1'b1);
        check("con_true_ifield", ifield,  12'h300);
        con_result = 1'b0;
        cycle(16'h2003);
        check("con_true_flush", ir_valid, 1'b0);
        cycle(16'h2004);

        // if CON false ahead of a long immediate discards both words
        cycle(16'hD005);
        cycle(16'h5000);
        check("skipimm_w1_valid", ir_valid, 1'b0);
        cycle(16'h1234);
        check("skipimm_w2_valid", ir_valid, 1'b0);
        check("skipimm_imm_we",   imm_we,   1'b0);
        cycle(16'h2005);
        check("skipimm_resume",   ir_valid, 1'b1);
        check("skipimm_imm_data", imm_data, 16'hBEEF);

        // call JA and goto B
        cycle(16'h8123);
        check("call_ja",        call_ja, 1'b1);
        check("call_ja_ifield", ifield,  12'h123);
        check("call_goto_ja",   goto_ja, 1'b0);
        cycle(16'h2006);
        check("call_flush", ir_valid, 1'b0);
        cycle(16'hC000);
        check("goto_b", goto_b, 1'b1);
        cycle(16'h2007);
        check("goto_b_flush", ir_valid, 1'b0);
        cycle(16'h2008);

`ifdef JTDSP16_ICALL_EN
        irq = 1'b1;
        cycle(16'h2009);
        check("irq_icall",  icall,    1'b1);
        check("irq_in_isr", in_isr,   1'b1);
        check("irq_bubble", ir_valid, 1'b0);
        cycle(16'h200A);
        check("irq_icall_once", icall,    1'b0);
        check("irq_isr_valid",  ir_valid, 1'b1);
        cycle(16'hC100);
        check("masked_icall", icall,  1'b0);
        check("iret_goto_b",  goto_b, 1'b1);
        check("iret_in_isr",  in_isr, 1'b1);
        cycle(16'h200B);
        check("iret_clear", in_isr,   1'b0);
        check("iret_flush", ir_valid, 1'b0);
        check("iret_icall", icall,    1'b0);
        cycle(16'h200C);
        check("post_iret_icall", icall, 1'b0);
        cycle(16'h200D);
        check("second_icall",  icall,  1'b1);
        check("second_in_isr", in_isr, 1'b1);
        irq = 1'b0;
        cycle(16'h200E);
        check("second_icall_once", icall, 1'b0);
`else
        irq = 1'b1;
        cycle(16'h2009);
        check("noirq_icall",  icall,    1'b0);
        check("noirq_in_isr", in_isr,   1'b0);
        check("noirq_valid",  ir_valid, 1'b1);
        cycle(16'hC100);
        check("noirq_iret_goto_b", goto_b, 1'b1);
        cycle(16'h200B);
        check("noirq_iret_flush", ir_valid, 1'b0);
        check("noirq_iret_isr",   in_isr,   1'b0);
        cycle(16'h200C);
        irq = 1'b0;
`endif

        // asynchronous reset while the data word is being absorbed
        cycle(16'h5000);
        cycle(16'h4321);
        check("pre_rst_imm_we",   imm_we,    1'b1);
        check("pre_rst_imm_data", imm_data,  16'h4321);
        check("pre_rst_state",    state_dbg, 3'd2);
        rst = 1'b1;
        #1;
        check("async_rst_ir",       ir,        16'h0000);
        check("async_rst_valid",    ir_valid,  1'b0);
        check("async_rst_imm_we",   imm_we,    1'b0);
        check("async_rst_imm_data", imm_data,  16'h0000);
        check("async_rst_in_isr",   in_isr,    1'b0);
        check("async_rst_state",    state_dbg, 3'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(16'h2468);
        check("post_rst_imm_we",   imm_we,   1'b0);
        check("post_rst_imm_data", imm_data, 16'h0000);
        check("post_rst_ir",       ir,       16'h2468);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
